frame_writer_444: RTL and testbench
===================================

// Module: frame_writer_444
// PURPOSE
//  Consumes 12-bit xR/GB-assembled RGB 444 pixels from the byte deserializer
//  and writes them into the frame-buffer BRAM write port. Tracks frame/line
//  position from VSYNC and HREF, generates linear write addresses (y*H_ACTIVE+x),
//  and reports frame completion and geometry errors. Runs entirely in the camera PCLK domain.
// PARAMETERS
//  H_ACTIVE  640  pixels per line stored
//  V_ACTIVE  480  lines per frame stored
//  ADDR_W    19   write address width; must satisfy 2**ADDR_W >= H_ACTIVE*V_ACTIVE
//  DATA_W    12   pixel width (RGB 444)
// PORTS
//  PCLK          in   1       camera pixel clock, all logic on posedge
//  RST           in   1       asynchronous, active-high reset
//  VSYNC         in   1       camera VSYNC, high during vertical blanking, PCLK-synchronous
//  HREF          in   1       camera HREF, high during active line, PCLK-synchronous
//  i_RGB_444     in   DATA_W  pixel from deserializer
//  i_valid       in   1       one-cycle strobe: i_RGB_444 holds a new pixel
//  o_wr_en       out  1       BRAM write enable
//  o_wr_addr     out  ADDR_W  BRAM write address
//  o_wr_data     out  DATA_W  BRAM write data
//  o_frame_done  out  1       one-cycle pulse at end of each captured frame
//  o_frame_err   out  1       valid with o_frame_done; 1 = geometry mismatch in that frame
//  o_busy        out  1       high while in s_ACTIVE
// BEHAVIOUR
//  - Reset: all outputs 0; x, y, line_base, addr counters 0; error flag 0; VSYNC/HREF
//    history flops 0; state s_WAIT_FRAME. Reset mid-frame abandons the frame; no writes
//    occur until the next VSYNC falling edge (no partial frames).
//  - Edges: vs_fall = prev VSYNC & ~VSYNC; vs_rise = ~prev & VSYNC; href_fall likewise.
//  - States: s_WAIT_FRAME -> s_ACTIVE on vs_fall (clear x, y, line_base, err).
//    s_ACTIVE -> s_DONE on vs_rise. s_DONE -> s_WAIT_FRAME unconditionally (1 cycle).
//    s_WAIT_FRAME ignores i_valid and HREF.
//  - Pixel write (s_ACTIVE, i_valid, x < H_ACTIVE, y < V_ACTIVE): next cycle o_wr_en=1,
//    o_wr_data = registered i_RGB_444, o_wr_addr = line_base + x; then x <= x+1.
//    Latency i_valid -> o_wr_en exactly 1 cycle; o_wr_en is 1-cycle per pixel.
//  - Overrun: i_valid with x == H_ACTIVE or y >= V_ACTIVE: pixel dropped, err <= 1.
//  - Line end (href_fall in s_ACTIVE): if x != H_ACTIVE and y < V_ACTIVE, err <= 1;
//    if y < V_ACTIVE: y <= y+1, line_base <= line_base + H_ACTIVE; x <= 0 always.
//    Short lines leave unwritten holes; next line still starts at its own base.
//  - Simultaneous i_valid & href_fall: pixel belongs to ending line (written at
//    line_base+x, counts toward x check), then line advance.
//  - Simultaneous i_valid & vs_rise: pixel written if in bounds, then go s_DONE.
//  - Frame end (entering s_DONE): o_frame_done=1 for one cycle; o_frame_err =
//    err | (y != V_ACTIVE), registered with the pulse; both 0 otherwise.
//  - Arithmetic: x width clog2(H_ACTIVE+1), y width clog2(V_ACTIVE+1), no wrap;
//    counters saturate at H_ACTIVE / V_ACTIVE. line_base is ADDR_W wide, never
//    exceeds (V_ACTIVE-1)*H_ACTIVE.
//  - o_busy = (state == s_ACTIVE).
// TESTING (bench uses H_ACTIVE=4, V_ACTIVE=3)
//  1 Assert RST mid-activity -> all outputs 0 immediately (async), state s_WAIT_FRAME.
//  2 VSYNC 1->0, 3 lines of 4 valid pixels (data 0x001..0x00C), VSYNC 0->1 -> 12 writes,
//    addr 0..11 in order, data matches, one o_frame_done with o_frame_err=0.
//  3 Line 1 has 3 pixels only -> writes addr 0-3,4-6,8-11; addr 7 never written; err=1.
//  4 Line 0 has 6 pixels -> pixels 5,6 dropped, no write beyond addr 3; err=1 at done.
//  5 Release RST with VSYNC low and HREF toggling -> zero writes until first VSYNC fall,
//    then next frame captured as scenario 2.
//  6 i_valid coincident with href_fall and with vs_rise -> pixel written at correct
//    addr (3 / 11), then line advance / single done pulse, one cycle later.

Source files
------------

// File: rtl/frame_writer_444.sv
// Frame-buffer writer for RGB 444 camera pixels: tracks frame/line position from
// VSYNC/HREF, writes pixels to linear BRAM addresses and flags geometry errors.
module frame_writer_444 #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19,
    parameter int DATA_W   = 12
) (
    input  logic              PCLK,
    input  logic              RST,
    input  logic              VSYNC,
    input  logic              HREF,
    input  logic [DATA_W-1:0] i_RGB_444,
    input  logic              i_valid,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_frame_done,
    output logic              o_frame_err,
    output logic              o_busy
);

    localparam int XW = $clog2(H_ACTIVE + 1);
    localparam int YW = $clog2(V_ACTIVE + 1);

    localparam logic [XW-1:0]     X_ZERO    = XW'(0);
    localparam logic [XW-1:0]     X_ONE     = XW'(1);
    localparam logic [XW-1:0]     X_MAX     = XW'(H_ACTIVE);
    localparam logic [YW-1:0]     Y_ZERO    = YW'(0);
    localparam logic [YW-1:0]     Y_ONE     = YW'(1);
    localparam logic [YW-1:0]     Y_MAX     = YW'(V_ACTIVE);
    localparam logic [YW-1:0]     Y_LAST    = YW'(V_ACTIVE - 1);
    localparam logic [ADDR_W-1:0] LB_ZERO   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE);

    typedef enum logic [1:0] {
        s_WAIT_FRAME = 2'd0,
        s_ACTIVE     = 2'd1,
        s_DONE       = 2'd2
    } state_t;

    state_t              state_r, state_next_s;
    logic                vsync_prev_r, href_prev_r;
    logic [XW-1:0]       x_r, x_next_s, x_pix_s;
    logic [YW-1:0]       y_r, y_next_s;
    logic [ADDR_W-1:0]   line_base_r, line_base_next_s;
    logic                err_r, err_next_s, err_pix_s;
    logic                wr_en_r, wr_en_next_s;
    logic [ADDR_W-1:0]   wr_addr_r, wr_addr_next_s;
    logic [DATA_W-1:0]   wr_data_r, wr_data_next_s;
    logic                done_r, done_next_s;
    logic                ferr_r, ferr_next_s;
    logic                busy_r;
    logic                vs_fall_s, vs_rise_s, href_fall_s;

    assign vs_fall_s   = vsync_prev_r & ~VSYNC;
    assign vs_rise_s   = ~vsync_prev_r & VSYNC;
    assign href_fall_s = href_prev_r & ~HREF;

    assign o_wr_en      = wr_en_r;
    assign o_wr_addr    = wr_addr_r;
    assign o_wr_data    = wr_data_r;
    assign o_frame_done = done_r;
    assign o_frame_err  = ferr_r;
    assign o_busy       = busy_r;

    // Next-state, position counters and write/frame-status outputs
    always_comb begin
        state_next_s     = state_r;
        x_next_s         = x_r;
        y_next_s         = y_r;
        line_base_next_s = line_base_r;
        err_next_s       = err_r;
        x_pix_s          = x_r;
        err_pix_s        = err_r;
        wr_en_next_s     = 1'b0;
        wr_addr_next_s   = wr_addr_r;
        wr_data_next_s   = wr_data_r;
        done_next_s      = 1'b0;
        ferr_next_s      = 1'b0;

        case (state_r)
            s_WAIT_FRAME: begin
                if (vs_fall_s) begin
                    state_next_s     = s_ACTIVE;
                    x_next_s         = X_ZERO;
                    y_next_s         = Y_ZERO;
                    line_base_next_s = LB_ZERO;
                    err_next_s       = 1'b0;
                end else begin
                    state_next_s = s_WAIT_FRAME;
                end
            end

            s_ACTIVE: begin
                // A pixel arriving with the line/frame end still belongs to the ending line
                if (i_valid) begin
                    if ((x_r < X_MAX) && (y_r < Y_MAX)) begin
                        wr_en_next_s   = 1'b1;
                        wr_addr_next_s = line_base_r + ADDR_W'(x_r);
                        wr_data_next_s = i_RGB_444;
                        x_pix_s        = x_r + X_ONE;
                    end else begin
                        err_pix_s = 1'b1;
                    end
                end else begin
                    x_pix_s = x_r;
                end

                if (href_fall_s) begin
                    if ((x_pix_s != X_MAX) && (y_r < Y_MAX)) begin
                        err_next_s = 1'b1;
                    end else begin
                        err_next_s = err_pix_s;
                    end
                    if (y_r < Y_MAX) begin
                        y_next_s = y_r + Y_ONE;
                    end else begin
                        y_next_s = y_r;
                    end
                    // line_base stops at the last stored line so it never points past the frame
                    if (y_r < Y_LAST) begin
                        line_base_next_s = line_base_r + LINE_STEP;
                    end else begin
                        line_base_next_s = line_base_r;
                    end
                    x_next_s = X_ZERO;
                end else begin
                    x_next_s   = x_pix_s;
                    err_next_s = err_pix_s;
                end

                if (vs_rise_s) begin
                    state_next_s = s_DONE;
                    done_next_s  = 1'b1;
                    ferr_next_s  = err_next_s | (y_next_s != Y_MAX);
                end else begin
                    state_next_s = s_ACTIVE;
                end
            end

            s_DONE: begin
                state_next_s = s_WAIT_FRAME;
            end

            default: begin
                state_next_s = s_WAIT_FRAME;
            end
        endcase
    end

    // State register, sync-edge history, counters and registered outputs
    always_ff @(posedge PCLK or posedge RST) begin
        if (RST) begin
            state_r      <= s_WAIT_FRAME;
            vsync_prev_r <= 1'b0;
            href_prev_r  <= 1'b0;
            x_r          <= X_ZERO;
            y_r          <= Y_ZERO;
            line_base_r  <= LB_ZERO;
            err_r        <= 1'b0;
            wr_en_r      <= 1'b0;
            wr_addr_r    <= LB_ZERO;
            wr_data_r    <= DATA_W'(0);
            done_r       <= 1'b0;
            ferr_r       <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            vsync_prev_r <= VSYNC;
            href_prev_r  <= HREF;
            x_r          <= x_next_s;
            y_r          <= y_next_s;
            line_base_r  <= line_base_next_s;
            err_r        <= err_next_s;
            wr_en_r      <= wr_en_next_s;
            wr_addr_r    <= wr_addr_next_s;
            wr_data_r    <= wr_data_next_s;
            done_r       <= done_next_s;
            ferr_r       <= ferr_next_s;
            busy_r       <= (state_next_s == s_ACTIVE);
        end
    end

endmodule

// File: tb/tb_frame_writer_444.sv
// Randomised scoreboard bench for frame_writer_444 with a 4x3 frame geometry.
module tb_frame_writer_444;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int AW = 4;
    localparam int DW = 12;

    logic          PCLK = 1'b0;
    logic          RST = 1'b1;
    logic          VSYNC = 1'b0;
    logic          HREF = 1'b0;
    logic          i_valid = 1'b0;
    logic [DW-1:0] i_RGB_444 = '0;
    logic          o_wr_en, o_frame_done, o_frame_err, o_busy;
    logic [AW-1:0] o_wr_addr;
    logic [DW-1:0] o_wr_data;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_wr[$];
    bit  exp_done[$];
    wr_t mon_w;
    bit  mon_d;
    int  tests = 0;
    int  fails = 0;
    int  wr_seen = 0;
    bit  use_seq = 1'b0;
    int  pix_seq = 0;
    int  line_cnt[8];

    frame_writer_444 #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .DATA_W(DW)) dut (
        .PCLK(PCLK), .RST(RST), .VSYNC(VSYNC), .HREF(HREF),
        .i_RGB_444(i_RGB_444), .i_valid(i_valid),
        .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
        .o_frame_done(o_frame_done), .o_frame_err(o_frame_err), .o_busy(o_busy)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic next_data(output logic [DW-1:0] d);
        if (use_seq) begin
            pix_seq++;
            d = DW'(pix_seq);
        end else begin
            d = DW'($urandom);
        end
    endtask

    // Monitor: pops expected writes / frame results whenever the DUT presents one
    always @(negedge PCLK) begin
        if (!RST) begin
            if (o_wr_en) begin
                wr_seen++;
                if (exp_wr.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: addr %0d data %h, none expected", o_wr_addr, o_wr_data);
                end else begin
                    mon_w = exp_wr.pop_front();
                    check("wr_addr", int'(o_wr_addr), int'(mon_w.addr));
                    check("wr_data", int'(o_wr_data), int'(mon_w.data));
                end
            end
            if (o_frame_done) begin
                if (exp_done.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: err %0d, no frame end expected", o_frame_err);
                end else begin
                    mon_d = exp_done.pop_front();
                    check("frame_err", int'(o_frame_err), int'(mon_d));
                end
            end
        end
    end

    // Drives one frame of n lines (pixel counts in line_cnt) and predicts its results.
    // coin: last pixel of each line shares the cycle HREF drops.
    // open_last: last pixel of the last line shares the VSYNC rise, line never closed.
    task automatic drive_frame(input int n, input bit coin, input bit open_last);
        int            err;
        int            closed;
        int            yv;
        bit            last_px;
        logic [DW-1:0] d;
        wr_t           w;
        err = 0;
        closed = 0;
        VSYNC = 1'b1; HREF = 1'b0; i_valid = 1'b0;
        repeat (3) step();
        VSYNC = 1'b0;
        step();
        step();
        check("busy_in_frame", int'(o_busy), 1);
        for (int l = 0; l < n; l++) begin
            HREF = 1'b1;
            step();
            for (int p = 0; p < line_cnt[l]; p++) begin
                repeat ($urandom_range(0, 1)) step();
                last_px = (p == line_cnt[l] - 1);
                next_data(d);
                if (l < V && p < H) begin
                    w.addr = AW'(l * H + p);
                    w.data = d;
                    exp_wr.push_back(w);
                end else begin
                    err = 1;
                end
                if (last_px && open_last && l == n - 1) VSYNC = 1'b1;
                else if (last_px && coin) HREF = 1'b0;
                i_RGB_444 = d;
                i_valid = 1'b1;
                step();
                i_valid = 1'b0;
            end
            if (!(open_last && l == n - 1)) begin
                if (l < V && line_cnt[l] != H) err = 1;
                closed++;
                HREF = 1'b0;
                step();
                step();
            end
        end
        yv = (closed > V) ? V : closed;
        if (yv != V) err = 1;
        exp_done.push_back(err != 0);
        if (open_last) begin
            HREF = 1'b0;
        end else begin
            VSYNC = 1'b1;
        end
        step();
        step();
        check("busy_after_done", int'(o_busy), 0);
    endtask

    initial begin
        int n;
        int wr0;
        bit op;

        // Reset state
        repeat (3) step();
        check("rst_wr_en", int'(o_wr_en), 0);
        check("rst_wr_addr", int'(o_wr_addr), 0);
        check("rst_frame_done", int'(o_frame_done), 0);
        check("rst_busy", int'(o_busy), 0);
        RST = 1'b0;

        // Reset asserted in the middle of a frame
        VSYNC = 1'b1;
        repeat (2) step();
        VSYNC = 1'b0;
        step();
        HREF = 1'b1;
        step();
        mon_w.addr = AW'(0);
        mon_w.data = 12'h5A5;
        exp_wr.push_back(mon_w);
        i_RGB_444 = 12'h5A5; i_valid = 1'b1;
        step();
        i_RGB_444 = 12'h3C3;
        step();
        check("pre_rst_wr_en", int'(o_wr_en), 1);
        check("pre_rst_wr_addr", int'(o_wr_addr), 1);
        RST = 1'b1;
        i_valid = 1'b0;
        #1;
        check("async_rst_wr_en", int'(o_wr_en), 0);
        check("async_rst_wr_addr", int'(o_wr_addr), 0);
        check("async_rst_wr_data", int'(o_wr_data), 0);
        check("async_rst_done", int'(o_frame_done), 0);
        check("async_rst_err", int'(o_frame_err), 0);
        check("async_rst_busy", int'(o_busy), 0);

        // Release reset with VSYNC low and HREF toggling: nothing may be written
        VSYNC = 1'b0;
        for (int i = 0; i < 3; i++) begin
            HREF = ~HREF;
            step();
        end
        RST = 1'b0;
        wr0 = wr_seen;
        for (int i = 0; i < 20; i++) begin
            HREF = ~HREF;
            i_valid = 1'($urandom_range(0, 1));
            i_RGB_444 = DW'($urandom);
            step();
        end
        i_valid = 1'b0;
        HREF = 1'b0;
        step();
        check("no_write_before_vsync", wr_seen - wr0, 0);
        check("no_busy_before_vsync", int'(o_busy), 0);

        // Clean frame with data 1..12
        use_seq = 1'b1;
        line_cnt[0] = 4; line_cnt[1] = 4; line_cnt[2] = 4;
        drive_frame(3, 1'b0, 1'b0);
        use_seq = 1'b0;

        // Short line 1 leaves a hole at addr 7
        line_cnt[0] = 4; line_cnt[1] = 3; line_cnt[2] = 4;
        drive_frame(3, 1'b0, 1'b0);

        // Overlong line 0 drops its extra pixels
        line_cnt[0] = 6; line_cnt[1] = 4; line_cnt[2] = 4;
        drive_frame(3, 1'b0, 1'b0);

        // Pixel coincident with HREF fall, last pixel coincident with VSYNC rise
        line_cnt[0] = 4; line_cnt[1] = 4; line_cnt[2] = 4;
        drive_frame(3, 1'b1, 1'b1);

        // Randomised geometries
        for (int f = 0; f < 10; f++) begin
            n = $urandom_range(2, 4);
            for (int l = 0; l < n; l++) begin
                line_cnt[l] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : 4;
            end
            op = ($urandom_range(0, 3) == 0);
            if (op && line_cnt[n - 1] == 0) line_cnt[n - 1] = 1;
            drive_frame(n, 1'($urandom_range(0, 1)), op);
        end

        repeat (5) step();
        check("writes_outstanding", exp_wr.size(), 0);
        check("frames_outstanding", exp_done.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
